timer_irq_source: RTL and testbench

//  Memory-mapped programmable timer that drives one CP0 interrupt input (INT1..INT7).

---
 rtl/timer_irq_source_pkg.sv | 23 ++
 rtl/timer_irq_source_prescaler.sv | 31 +++
 rtl/timer_irq_source.sv | 160 ++++++++++++++++
 tb/tb_timer_irq_source.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_irq_source_pkg.sv
// Shared register map and field positions for the timer interrupt source.
package timer_irq_source_pkg;

  // Word offsets on the peripheral bus.
  typedef enum logic [1:0] {
    ADDR_CTRL    = 2'd0,
    ADDR_COUNT   = 2'd1,
    ADDR_COMPARE = 2'd2,
    ADDR_STATUS  = 2'd3
  } reg_addr_e;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_PRE_LSB    = 8;
  localparam int CTRL_PRE_MAX_W  = 8;

  // STATUS bit positions.
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_RUNNING_BIT = 1;

endpackage

// File: rtl/timer_irq_source_prescaler.sv
// Clock prescaler: counts 0..pre while enabled and pulses tick when it
// reaches pre. Disabling or restarting returns the phase to 0.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             en,
  input  logic             restart,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] phase;

  assign tick = en && (phase == pre);

  // Phase counter: wraps after the tick cycle, parked at 0 when disabled.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      phase <= '0;
    end else if (!en || restart || tick) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of block ordering.
      phase <= '0;
    end else begin
      phase <= phase + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped programmable timer driving one CP0 interrupt pin.
// A prescaled up-counter is compared with COMPARE on every tick; a match
// sets a sticky PENDING flag which, gated by IRQ_EN, drives a registered IRQ.
module timer_irq_source
  import timer_irq_source_pkg::*;
#(
  parameter int          CNT_W         = 32,
  parameter int          PRE_W         = 8,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        BUS_EN,
  input  logic        BUS_WE,
  input  logic [1:0]  BUS_ADDR,
  input  logic [31:0] BUS_WDATA,
  output logic [31:0] BUS_RDATA,
  output logic        IRQ
);

  // Register state.
  logic             en;
  logic             auto_reload;
  logic             irq_en;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] compare;
  logic             pending;

  // Bus decode.
  logic       rd_access;
  logic       ctrl_wr;
  logic       count_wr;
  logic       compare_wr;
  logic       status_wr;
  reg_addr_e  addr;

  assign addr       = reg_addr_e'(BUS_ADDR);
  assign rd_access  = BUS_EN && !BUS_WE;
  assign ctrl_wr    = BUS_EN && BUS_WE && (addr == ADDR_CTRL);
  assign count_wr   = BUS_EN && BUS_WE && (addr == ADDR_COUNT);
  assign compare_wr = BUS_EN && BUS_WE && (addr == ADDR_COMPARE);
  assign status_wr  = BUS_EN && BUS_WE && (addr == ADDR_STATUS);

  // Bits of the write bus that no register field uses.
  logic wdata_unused;
  assign wdata_unused = ^{BUS_WDATA[31:CTRL_PRE_LSB+PRE_W],
                          BUS_WDATA[CTRL_PRE_LSB-1:CTRL_IRQ_EN_BIT+1]};

  // Tick qualification. A COUNT write overrides the whole tick (software's
  // value wins and the prescaler restarts); a CTRL write that clears EN
  // discards the tick so a stopped timer never flags late.
  logic tick;
  logic tick_eff;
  logic match;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .en      (en),
    .restart (count_wr),
    .pre     (pre),
    .tick    (tick)
  );

  assign tick_eff = tick && !count_wr && !(ctrl_wr && !BUS_WDATA[CTRL_EN_BIT]);
  // Compares against the pre-edge COMPARE, so a coincident COMPARE write
  // only affects later ticks.
  assign match    = tick_eff && (count == compare);

  // CTRL register: software writes win; a one-shot match stops the timer.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      pre         <= '0;
    end else if (ctrl_wr) begin
      en          <= BUS_WDATA[CTRL_EN_BIT];
      auto_reload <= BUS_WDATA[CTRL_AUTO_BIT];
      irq_en      <= BUS_WDATA[CTRL_IRQ_EN_BIT];
      pre         <= BUS_WDATA[CTRL_PRE_LSB +: PRE_W];
    end else if (match && !auto_reload) begin
      en <= 1'b0;
    end
  end

  // Counter: loads on write, otherwise advances (or reloads) on a tick.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count <= '0;
    end else if (count_wr) begin
      count <= BUS_WDATA[CNT_W-1:0];
    end else if (tick_eff) begin
      count <= (match && auto_reload) ? '0 : count + CNT_W'(1);
    end
  end

  // COMPARE register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      compare <= RESET_COMPARE[CNT_W-1:0];
    end else if (compare_wr) begin
      compare <= BUS_WDATA[CNT_W-1:0];
    end
  end

  // Sticky PENDING: a hardware match takes priority over a W1C.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pending <= 1'b0;
    end else if (match) begin
      pending <= 1'b1;
    end else if (status_wr && BUS_WDATA[STATUS_PENDING_BIT]) begin
      pending <= 1'b0;
    end
  end

  // Level interrupt, one register stage behind PENDING and IRQ_EN.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= pending && irq_en;
    end
  end

  // Read mux from pre-edge register values; unused bits read 0.
  logic [31:0] rdata_next;
  always_comb begin
    // NOTE: default assignment first so no path leaves rdata_next unassigned,
    // which would otherwise infer a latch.
    rdata_next = '0;
    case (addr)
      ADDR_CTRL: begin
        rdata_next[CTRL_EN_BIT]               = en;
        rdata_next[CTRL_AUTO_BIT]             = auto_reload;
        rdata_next[CTRL_IRQ_EN_BIT]           = irq_en;
        rdata_next[CTRL_PRE_LSB +: PRE_W]     = pre;
      end
      ADDR_COUNT:   rdata_next[CNT_W-1:0] = count;
      ADDR_COMPARE: rdata_next[CNT_W-1:0] = compare;
      ADDR_STATUS: begin
        rdata_next[STATUS_PENDING_BIT] = pending;
        rdata_next[STATUS_RUNNING_BIT] = en;
      end
      default: rdata_next = '0;
    endcase
  end

  // Registered read data: updates only on a read access, holds otherwise.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      BUS_RDATA <= '0;
    end else if (rd_access) begin
      BUS_RDATA <= rdata_next;
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Scoreboard bench for timer_irq_source: a driver issues bus operations and
// pushes the reference model's expected read data and IRQ level into queues;
// an independent monitor pops and compares after every clock edge.
module tb_timer_irq_source;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        BUS_EN;
  logic        BUS_WE;
  logic [1:0]  BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA;
  logic        IRQ;

  always #5 CLK = ~CLK;

  timer_irq_source dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .BUS_EN    (BUS_EN),
    .BUS_WE    (BUS_WE),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_WDATA (BUS_WDATA),
    .BUS_RDATA (BUS_RDATA),
    .IRQ       (IRQ)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register values plus the prescaler phase.
  bit        m_en, m_auto, m_irqen, m_pend, m_irq;
  bit [7:0]  m_pre;
  bit [31:0] m_count, m_cmp;
  int        m_phase;

  logic [31:0] rd_q[$];
  bit          irq_q[$];

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_irqen = 0; m_pend = 0; m_irq = 0;
    m_pre = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_phase = 0;
  endtask

  // One clock of the timer's rules, given the bus operation in that clock.
  task automatic model_step(input bit e, input bit w, input bit [1:0] a, input bit [31:0] d);
    bit tick, ctrl_wr, count_wr, cmp_wr, st_wr, take, hit;
    bit [31:0] rv;
    tick     = m_en && (m_phase == int'(m_pre));
    ctrl_wr  = e && w && a == 2'd0;
    count_wr = e && w && a == 2'd1;
    cmp_wr   = e && w && a == 2'd2;
    st_wr    = e && w && a == 2'd3;
    take     = tick && !count_wr && !(ctrl_wr && !d[0]);
    hit      = take && (m_count == m_cmp);

    if (e && !w) begin
      case (a)
        2'd0:    rv = {16'h0, m_pre, 5'h0, m_irqen, m_auto, m_en};
        2'd1:    rv = m_count;
        2'd2:    rv = m_cmp;
        default: rv = {30'h0, m_en, m_pend};
      endcase
      rd_q.push_back(rv);
    end
    irq_q.push_back(m_pend && m_irqen);

    if (!m_en || count_wr || tick) m_phase = 0;
    else m_phase = m_phase + 1;

    if (count_wr)   m_count = d;
    else if (take)  m_count = (hit && m_auto) ? 32'h0 : m_count + 32'h1;
    if (cmp_wr)     m_cmp = d;
    if (hit)        m_pend = 1;
    else if (st_wr && d[0]) m_pend = 0;
    if (ctrl_wr) begin
      m_en = d[0]; m_auto = d[1]; m_irqen = d[2]; m_pre = d[15:8];
    end else if (hit && !m_auto) begin
      m_en = 0;
    end
  endtask

  task automatic do_op(input bit e, input bit w, input bit [1:0] a, input bit [31:0] d);
    @(negedge CLK);
    BUS_EN = e; BUS_WE = w; BUS_ADDR = a; BUS_WDATA = d;
    model_step(e, w, a, d);
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d); do_op(1, 1, a, d); endtask
  task automatic rd(input bit [1:0] a);                     do_op(1, 0, a, 32'h0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_op(0, 0, 2'd0, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESETN = 1; BUS_EN = 0; BUS_WE = 0; BUS_ADDR = 0; BUS_WDATA = 0;
    model_reset();
    model_step(0, 0, 2'd0, 32'h0);
  endtask

  // Monitor: after each live edge, compare IRQ and any read result.
  initial begin
    logic was_rd, live;
    forever begin
      @(posedge CLK);
      was_rd = BUS_EN && !BUS_WE;
      live   = RESETN;
      #1;
      if (live && irq_q.size() > 0) begin
        check("irq", {31'h0, IRQ}, {31'h0, irq_q.pop_front()});
        if (was_rd) begin
          if (rd_q.size() == 0) check("rd_queue_underflow", 32'h1, 32'h0);
          else                  check("rdata", BUS_RDATA, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit [31:0] d;
    int        k;
    RESETN = 0; BUS_EN = 0; BUS_WE = 0; BUS_ADDR = 0; BUS_WDATA = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 check("reset_irq", {31'h0, IRQ}, 32'h0);
    check("reset_rdata", BUS_RDATA, 32'h0);
    release_reset();

    // Reset register values.
    rd(0); rd(1); rd(2); rd(3);

    // Free-running, PRE=0, COMPARE=5: match on 6th tick, reload to 0.
    wr(2, 32'd5); wr(0, 32'h7); wr(1, 32'h0);
    idle(7); rd(1); rd(3); idle(1); rd(1);
    wr(3, 32'h1); wr(0, 32'h0); wr(3, 32'h1);

    // One-shot, PRE=3, COMPARE=2: match 12 clocks after enable, freeze at 3.
    wr(1, 32'h0); wr(2, 32'd2); wr(0, 32'h0000_0305);
    idle(14); rd(0); rd(1); rd(3); idle(3); rd(1);

    // IRQ from held PENDING once IRQ_EN is set; W1C of 0 then 1.
    wr(0, 32'h4); idle(3); wr(3, 32'h0); idle(2); wr(3, 32'h1); idle(3); rd(3);
    // IRQ_EN dropped while pending: IRQ falls, PENDING kept.
    wr(0, 32'h0000_0305); idle(14); wr(0, 32'h4); idle(2); wr(0, 32'h0); idle(2); rd(3);
    wr(3, 32'h1);

    // W1C coincident with a match tick: set wins.
    wr(2, 32'd3); wr(0, 32'h7); wr(1, 32'h0);
    idle(7); wr(3, 32'h1); idle(2); rd(3);

    // Wrap from all-ones is silent; match at 3.
    wr(0, 32'h0); wr(3, 32'h1); wr(2, 32'd3); wr(0, 32'h7); wr(1, 32'hFFFF_FFFF);
    idle(1); rd(3); idle(5); rd(3); rd(1);

    // Async reset while IRQ is high.
    idle(1);
    @(posedge CLK); #3;
    check("pre_reset_irq_high", {31'h0, IRQ}, 32'h1);
    RESETN = 0;
    #1;
    check("async_reset_irq", {31'h0, IRQ}, 32'h0);
    check("async_reset_rdata", BUS_RDATA, 32'h0);
    repeat (2) @(posedge CLK);
    release_reset();
    idle(5); rd(1); rd(0); rd(2); rd(3);
    wr(0, 32'h7); idle(4); rd(1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 99);
      if (k < 55) idle(1);
      else if (k < 75) rd(2'($urandom_range(0, 3)));
      else begin
        d = $urandom;
        case ($urandom_range(0, 3))
          0: begin d[15:8] = 8'($urandom_range(0, 3)); wr(0, d); end
          1: wr(1, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                               : 32'($urandom_range(0, 12)));
          2: wr(2, 32'($urandom_range(0, 12)));
          default: wr(3, d);
        endcase
      end
    end
    idle(2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && (irq_q.size() > 0 || rd_q.size() > 0); i++) @(posedge CLK);
    #2;
    check("drain_irq_q", irq_q.size(), 32'h0);
    check("drain_rd_q", rd_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
